// File: rtl/path_node_buffer.sv
// Captures a planned node list from the path-planning driver and serves it node by node
// to the navigation FSM, exposing the current node and a one-node look-ahead.
module path_node_buffer #(
    parameter int unsigned NODE_W = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_3125KHz,
    input  logic              rst_n,
    input  logic [NODE_W-1:0] path_node,
    input  logic              path_valid,
    input  logic [NODE_W-1:0] end_point,
    input  logic              clear,
    input  logic              node_adv,
    output logic [NODE_W-1:0] cur_node,
    output logic [NODE_W-1:0] next_node,
    output logic              node_valid,
    output logic              has_next,
    output logic              path_done,
    output logic [ADDR_W:0]   path_len,
    output logic              path_err
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SERVE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                err_q, err_d;

    logic [NODE_W-1:0]   mem_q [DEPTH];
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [NODE_W-1:0]   wdata;

    logic [NODE_W-1:0]   cur_q, cur_d;
    logic [NODE_W-1:0]   next_q, next_d;
    logic                valid_q, valid_d;
    logic                has_next_q, has_next_d;
    logic                done_q, done_d;

    logic [ADDR_W-1:0]   nxt_addr;
    logic [NODE_W-1:0]   cur_rd, nxt_rd;

    // Next-state logic; the write pointer is the current list length.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        err_d    = err_q;
        we       = 1'b0;
        waddr    = ADDR_W'(len_q);
        wdata    = path_node;

        if (clear) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            len_d    = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, SERVE, DONE: begin
                    if (path_valid) begin
                        we       = 1'b1;
                        waddr    = '0;
                        rd_ptr_d = '0;
                        len_d    = LEN_W'(1);
                        err_d    = 1'b0;
                        state_d  = (path_node == end_point) ? DONE : CAPTURE;
                    end else if (state_q == SERVE && node_adv) begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        if (LEN_W'(rd_ptr_d) == len_q - LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                CAPTURE: begin
                    rd_ptr_d = '0;
                    if (path_valid) begin
                        if (len_q == LEN_W'(DEPTH)) begin
                            // List full: node is dropped but EP still closes it.
                            err_d = 1'b1;
                            if (path_node == end_point) begin
                                state_d = SERVE;
                            end
                        end else begin
                            we    = 1'b1;
                            len_d = len_q + LEN_W'(1);
                            if (path_node == end_point) begin
                                state_d = (len_d == LEN_W'(1)) ? DONE : SERVE;
                            end
                        end
                    end else if (len_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (len_q == LEN_W'(1)) ? DONE : SERVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory read with write bypass so outputs can be registered from next-state values.
    always_comb begin
        nxt_addr = rd_ptr_d + ADDR_W'(1);
        cur_rd   = (we && waddr == rd_ptr_d) ? wdata : mem_q[rd_ptr_d];
        nxt_rd   = (we && waddr == nxt_addr) ? wdata : mem_q[nxt_addr];
    end

    always_comb begin
        valid_d    = (state_d == SERVE) || (state_d == DONE);
        done_d     = (state_d == DONE);
        has_next_d = (state_d == SERVE) && (LEN_W'(rd_ptr_d) + LEN_W'(1) < len_d);
        cur_d      = valid_d ? cur_rd : '0;
        next_d     = has_next_d ? nxt_rd : '0;
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            cur_q      <= '0;
            next_q     <= '0;
            valid_q    <= 1'b0;
            has_next_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            err_q      <= err_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
            valid_q    <= valid_d;
            has_next_q <= has_next_d;
            done_q     <= done_d;
        end
    end

    // Node storage; contents are don't-care after reset.
    always_ff @(posedge clk_3125KHz) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign cur_node   = cur_q;
    assign next_node  = next_q;
    assign node_valid = valid_q;
    assign has_next   = has_next_q;
    assign path_done  = done_q;
    assign path_len   = len_q;
    assign path_err   = err_q;

endmodule

// File: tb/tb_path_node_buffer.sv
// Directed and randomized bench for path_node_buffer against a queue-based list model.
module tb_path_node_buffer;

    localparam int unsigned NODE_W = 5;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk_3125KHz = 1'b0;
    logic              rst_n;
    logic [NODE_W-1:0] path_node;
    logic              path_valid;
    logic [NODE_W-1:0] end_point;
    logic              clear;
    logic              node_adv;
    logic [NODE_W-1:0] cur_node;
    logic [NODE_W-1:0] next_node;
    logic              node_valid;
    logic              has_next;
    logic              path_done;
    logic [ADDR_W:0]   path_len;
    logic              path_err;

    path_node_buffer #(.NODE_W(NODE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_3125KHz(clk_3125KHz),
        .rst_n      (rst_n),
        .path_node  (path_node),
        .path_valid (path_valid),
        .end_point  (end_point),
        .clear      (clear),
        .node_adv   (node_adv),
        .cur_node   (cur_node),
        .next_node  (next_node),
        .node_valid (node_valid),
        .has_next   (has_next),
        .path_done  (path_done),
        .path_len   (path_len),
        .path_err   (path_err)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stored list, the serving index and two phase flags.
    int m_list[$];
    int m_idx;
    bit m_cap;
    bit m_srv;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_list.delete();
        m_idx = 0;
        m_cap = 1'b0;
        m_srv = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit pv, input int node, input int ep, input bit clr, input bit adv);
        if (clr) begin
            model_reset();
        end else if (!m_cap && pv) begin
            m_list.delete();
            m_list.push_back(node);
            m_idx = 0;
            m_err = 1'b0;
            m_cap = (node != ep);
            m_srv = (node == ep);
        end else if (m_cap) begin
            if (pv) begin
                if (m_list.size() == DEPTH) m_err = 1'b1;
                else m_list.push_back(node);
                if (node == ep) begin
                    m_cap = 1'b0;
                    m_srv = 1'b1;
                end
            end else begin
                m_cap = 1'b0;
                if (m_list.size() != 0) begin
                    m_err = 1'b1;
                    m_srv = 1'b1;
                end
            end
        end else if (m_srv && adv && m_idx < m_list.size() - 1) begin
            m_idx++;
        end
    endtask

    task automatic check_all(input string ctx);
        int  e_cur, e_next;
        bit  e_hn, e_done;
        e_hn   = m_srv && (m_idx < m_list.size() - 1);
        e_done = m_srv && (m_idx == m_list.size() - 1);
        e_cur  = m_srv ? m_list[m_idx] : 0;
        e_next = e_hn ? m_list[m_idx + 1] : 0;
        chk({ctx, ".cur_node"},   32'(cur_node),   32'(e_cur));
        chk({ctx, ".next_node"},  32'(next_node),  32'(e_next));
        chk({ctx, ".node_valid"}, 32'(node_valid), 32'(m_srv));
        chk({ctx, ".has_next"},   32'(has_next),   32'(e_hn));
        chk({ctx, ".path_done"},  32'(path_done),  32'(e_done));
        chk({ctx, ".path_len"},   32'(path_len),   32'(m_list.size()));
        chk({ctx, ".path_err"},   32'(path_err),   32'(m_err));
    endtask

    // One clock: drive at the falling edge, update model at the rising edge, check at the next fall.
    task automatic cycle(input bit pv, input int node, input int ep, input bit clr, input bit adv,
                         input string ctx);
        path_valid = pv;
        path_node  = NODE_W'(node);
        end_point  = NODE_W'(ep);
        clear      = clr;
        node_adv   = adv;
        @(posedge clk_3125KHz);
        model_step(pv, node, ep, clr, adv);
        @(negedge clk_3125KHz);
        check_all(ctx);
    endtask

    int  ep_r;
    int  node_r;
    bit  pv_r;

    initial begin
        rst_n      = 1'b0;
        path_valid = 1'b0;
        path_node  = '0;
        end_point  = '0;
        clear      = 1'b0;
        node_adv   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_3125KHz);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk_3125KHz);

        // Four-node path ending at EP, then walk it to the end.
        cycle(1, 3, 20, 0, 0, "t1.n0");
        cycle(1, 7, 20, 0, 0, "t1.n1");
        cycle(1, 12, 20, 0, 0, "t1.n2");
        cycle(1, 20, 20, 0, 0, "t1.ep");
        cycle(0, 0, 20, 0, 0, "t1.hold");
        for (int i = 0; i < 4; i++) cycle(0, 0, 20, 0, 1, $sformatf("t2.adv%0d", i));
        cycle(0, 0, 20, 0, 0, "t2.hold");

        // Single-node path where the first node is the EP.
        cycle(1, 9, 9, 0, 0, "t3.single");
        cycle(0, 0, 9, 0, 1, "t3.adv");

        // List closed by path_valid dropping before EP.
        cycle(1, 1, 5, 0, 0, "t4.n0");
        cycle(1, 2, 5, 0, 0, "t4.n1");
        cycle(1, 3, 5, 0, 0, "t4.n2");
        cycle(0, 0, 5, 0, 0, "t4.close");

        // Overflow: 17 nodes, no EP; walk to the last stored slot.
        for (int i = 0; i < 17; i++) cycle(1, i, 31, 0, 0, $sformatf("t5.n%0d", i));
        cycle(0, 0, 31, 0, 0, "t5.close");
        for (int i = 0; i < 16; i++) cycle(0, 0, 31, 0, 1, $sformatf("t5.adv%0d", i));

        // Clear beats node_adv while serving.
        cycle(1, 3, 20, 0, 0, "t6.n0");
        cycle(1, 7, 20, 0, 0, "t6.n1");
        cycle(1, 12, 20, 0, 0, "t6.n2");
        cycle(1, 20, 20, 0, 0, "t6.ep");
        cycle(0, 0, 20, 0, 1, "t6.adv");
        cycle(1, 25, 20, 1, 1, "t6.clear");

        // Asynchronous reset in the middle of a capture.
        cycle(1, 4, 30, 0, 0, "t6.c0");
        cycle(1, 6, 30, 0, 0, "t6.c1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async_rst");
        @(negedge clk_3125KHz);
        rst_n = 1'b1;
        cycle(0, 0, 30, 0, 0, "t6.post_rst");

        // Randomized bursts with random EPs, advances and occasional clears.
        ep_r = int'($urandom_range(0, 31));
        pv_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) ep_r = int'($urandom_range(0, 31));
            pv_r   = pv_r ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            node_r = ($urandom_range(0, 9) == 0) ? ep_r : int'($urandom_range(0, 31));
            cycle(pv_r, node_r, ep_r, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
